// File: rtl/mem_or_io_ctrl.sv
// mem_or_io_ctrl: data-side load/store controller routing CPU accesses to RAM or memory-mapped LED/switch/7-seg IO.
module mem_or_io_ctrl (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [31:0] ALU_Result,
  input  logic [31:0] Write_Data,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] mem_rdata,
  input  logic [23:0] switch_in,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] Read_Data,
  output logic        Stall,
  output logic        Addr_Err,
  output logic [23:0] led_out,
  output logic [31:0] seg_out
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t state, state_nxt;
  logic [23:0] sw_meta, sw_sync;
  logic is_ram, is_led, is_sw, is_seg, req, err, ok;
  assign mem_addr  = ALU_Result[15:2];
  assign mem_wdata = Write_Data;
  assign is_ram = ALU_Result[31:16] == 16'h0000;
  assign is_led = ALU_Result == 32'hFFFF_FC60;
  assign is_sw  = ALU_Result == 32'hFFFF_FC70;
  assign is_seg = ALU_Result == 32'hFFFF_FC80;
  assign req = MemRead | MemWrite;
  assign err = req && ((MemRead && MemWrite) || (|ALU_Result[1:0]) ||
               !(is_ram || is_led || is_sw || is_seg) ||
               (MemWrite && is_sw) || (MemRead && (is_led || is_seg)));
  // A legal access only starts from IDLE; RD_WAIT merely completes the pending load.
  assign ok = (state == IDLE) && req && !err;
  always_comb begin
    state_nxt = IDLE;
    Stall     = 1'b0;
    mem_we    = 1'b0;
    Addr_Err  = 1'b0;
    Read_Data = '0;
    if (rst_n) begin
      if (state == RD_WAIT) begin
        Read_Data = mem_rdata;
      end else begin
        Addr_Err  = err;
        Stall     = ok && MemRead && is_ram;
        state_nxt = (ok && MemRead && is_ram) ? RD_WAIT : IDLE;
        mem_we    = ok && MemWrite && is_ram;
        Read_Data = (ok && MemRead && is_sw) ? {8'h00, sw_sync} : '0;
      end
    end
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      led_out <= '0;
      seg_out <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      state   <= state_nxt;
      sw_meta <= switch_in;
      sw_sync <= sw_meta;
      if (ok && MemWrite && is_led) led_out <= Write_Data[23:0];
      if (ok && MemWrite && is_seg) seg_out <= Write_Data;
    end
  end
endmodule

// File: tb/tb_mem_or_io_ctrl.sv
// tb_mem_or_io_ctrl: scoreboard bench with a word-array RAM, an address-map reference model and randomized accesses.
module tb_mem_or_io_ctrl;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALU_Result = '0, Write_Data = '0, mem_rdata;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [23:0] switch_in = '0;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, Read_Data, seg_out;
  logic        mem_we, Stall, Addr_Err;
  logic [23:0] led_out;

  mem_or_io_ctrl dut (
    .clock(clock), .rst_n(rst_n), .ALU_Result(ALU_Result), .Write_Data(Write_Data),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_rdata(mem_rdata), .switch_in(switch_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .Read_Data(Read_Data),
    .Stall(Stall), .Addr_Err(Addr_Err), .led_out(led_out), .seg_out(seg_out)
  );

  always #5 clock = ~clock;

  logic [31:0] ram [0:16383];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        we;
    int          stalls;
    logic [13:0] addr;
    logic [23:0] led;
    logic [31:0] seg;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] ref_mem [0:16383];
  logic [23:0] led_m = '0, sw_m = '0;
  logic [31:0] seg_m = '0;
  int vectors = 0, miscompares = 0, stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: classify the address into a region, then apply the access rules.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int region, n;
    logic bad, st;
    case (a)
      32'hFFFF_FC60: region = 1;
      32'hFFFF_FC70: region = 2;
      32'hFFFF_FC80: region = 3;
      default:       region = (a < 32'h0001_0000) ? 0 : 4;
    endcase
    bad = (rd && wr) || (a % 4 != 0) || region == 4 || (wr && region == 2) ||
          (rd && (region == 1 || region == 3));
    e.err    = bad;
    e.rdata  = (!bad && rd && region == 0) ? ref_mem[a / 4 % 16384] :
               (!bad && rd && region == 2) ? {8'h00, sw_m} : 32'h0;
    e.we     = !bad && wr && region == 0;
    e.stalls = (!bad && rd && region == 0) ? 1 : 0;
    e.addr   = 14'(a / 4);
    e.led    = led_m;
    e.seg    = seg_m;
    exp_q.push_back(e);
    if (!bad && wr && region == 0) ref_mem[a / 4 % 16384] = wd;
    if (!bad && wr && region == 1) led_m = wd[23:0];
    if (!bad && wr && region == 3) seg_m = wd;
    MemRead = rd; MemWrite = wr; ALU_Result = a; Write_Data = wd;
    n = 0;
    do begin
      @(negedge clock); st = Stall;
      @(posedge clock); #1; n++;
    end while (st && n < 4);
    if (st) chk("stall_timeout", 32'(n), 32'd2);
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic set_switches(input logic [23:0] v);
    switch_in = v; sw_m = v;
    idle(2);
  endtask

  // Monitor: pops one expectation per completed access (request present and not stalled).
  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      stall_cnt = 0;
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_err", 32'(Addr_Err), 32'd0);
      chk("rst_rdata", Read_Data, 32'd0);
    end else if (MemRead || MemWrite) begin
      if (Stall) begin
        stall_cnt++;
        chk("stall_no_we", 32'(mem_we), 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("addr_err", 32'(Addr_Err), 32'(e.err));
        chk("read_data", Read_Data, e.rdata);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("led_out", 32'(led_out), 32'(e.led));
        chk("seg_out", seg_out, e.seg);
        stall_cnt = 0;
      end
    end else begin
      chk("idle_stall", 32'(Stall), 32'd0);
      chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_rdata", Read_Data, 32'd0);
      chk("idle_err", 32'(Addr_Err), 32'd0);
    end
  end

  initial begin
    logic [31:0] v, a;
    int c, r;
    for (int i = 0; i < 16384; i++) begin
      v = $urandom; ram[i] = v; ref_mem[i] = v;
    end
    ram[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_led", 32'(led_out), 32'd0);
    chk("reset_seg", seg_out, 32'd0);
    rst_n = 1'b1;
    idle(1);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    issue(1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    set_switches(24'h00A5A5);
    issue(1'b1, 1'b0, 32'hFFFF_FC70, 32'h0);
    issue(1'b0, 1'b1, 32'hFFFF_FC60, 32'h0012_3456);
    issue(1'b0, 1'b1, 32'hFFFF_FC80, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 32'h0000_0002, 32'h0);
    issue(1'b0, 1'b1, 32'h1000_0000, 32'h0000_0001);
    issue(1'b1, 1'b1, 32'hFFFF_FC60, 32'h00FF_FFFF);
    issue(1'b0, 1'b1, 32'hFFFF_FC70, 32'h0000_0055);
    issue(1'b1, 1'b0, 32'hFFFF_FC60, 32'h0);
    issue(1'b0, 1'b1, 32'hFFFF_FC62, 32'h0000_0077);
    idle(1);
    chk("led_after_errs", 32'(led_out), 32'h0012_3456);
    // Reset while the load sits in RD_WAIT: outputs must drop at once.
    MemRead = 1'b1; ALU_Result = 32'h0000_0010;
    @(negedge clock); @(posedge clock); #1;
    rst_n = 1'b0; led_m = '0; seg_m = '0; sw_m = '0; switch_in = '0;
    #1;
    chk("abort_stall", 32'(Stall), 32'd0);
    chk("abort_rdata", Read_Data, 32'd0);
    chk("abort_led", 32'(led_out), 32'd0);
    @(negedge clock); @(posedge clock); #1;
    MemRead = 1'b0; rst_n = 1'b1;
    idle(1);
    issue(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 15) == 0) set_switches(24'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
      c = $urandom_range(0, 9);
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) * 4;
      case (c)
        5: a = 32'hFFFF_FC60;
        6: a = 32'hFFFF_FC70;
        7: a = 32'hFFFF_FC80;
        8: a = 32'h0001_0000 + ($urandom & 32'h0FFF_FFFC);
        9: a = a | 32'($urandom_range(1, 3));
        default: ;
      endcase
      issue(r < 5, r >= 5, a, $urandom);
    end
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_led", 32'(led_out), 32'(led_m));
    chk("final_seg", seg_out, seg_m);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_or_io_ctrl.md
MEM_OR_IO_CTRL -- requirements
Module: mem_or_io_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Port: clock  in  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: ALU_Result  in  32  byte address from the ALU (lw/sw effective address).
REQ-005 Port: Write_Data  in  32  store data (rt register value).
REQ-006 Port: MemRead  in  1  lw request.
REQ-007 Port: MemWrite  in  1  sw request.
REQ-008 Port: mem_rdata  in  32  data RAM read port, valid one cycle after mem_addr is presented.
REQ-009 Port: switch_in  in  24  asynchronous board switches.
REQ-010 Port: mem_addr  out  14  word address to RAM, equal to ALU_Result[15:2].
REQ-011 Port: mem_wdata  out  32  equal to Write_Data.
REQ-012 Port: mem_we  out  1  RAM write enable.
REQ-013 Port: Read_Data  out  32  load result to writeback.
REQ-014 Port: Stall  out  1  freezes PC and pipeline registers while high.
REQ-015 Port: Addr_Err  out  1  illegal access flag.
REQ-016 Port: led_out  out  24  registered LED value.
REQ-017 Port: seg_out  out  32  registered 7-segment value.

Function
REQ-018 Address map SHALL be: RAM 0x0000_0000-0x0000_FFFF; LED 0xFFFF_FC60 (write-only); SWITCH 0xFFFF_FC70 (read-only); SEG 0xFFFF_FC80 (write-only); all other addresses unmapped.
REQ-019 The FSM SHALL have two states, IDLE and RD_WAIT.
REQ-020 IDLE with MemRead=1, MemWrite=0 and an aligned RAM address: Stall=1 combinationally, next state RD_WAIT.
REQ-021 In RD_WAIT: Stall=0, Read_Data=mem_rdata, next state IDLE unconditionally; a RAM load SHALL therefore take exactly 2 cycles.
REQ-022 MemRead is not re-evaluated in RD_WAIT; the held instruction SHALL NOT re-trigger a load.
REQ-023 RAM store: in IDLE, MemWrite=1, MemRead=0, aligned address gives mem_we=1 in the same cycle, Stall=0, 1 cycle total.
REQ-024 Switch read: switch_in SHALL pass through a 2-flop synchronizer; Read_Data={8'h00, synced switches}, Stall=0, 1 cycle.
REQ-025 LED/SEG write: led_out<=Write_Data[23:0] / seg_out<=Write_Data at the clock edge of the access cycle; mem_we=0.
REQ-026 Addr_Err=1 (combinational, that cycle only) SHALL be raised for: ALU_Result[1:0]!=0 with MemRead or MemWrite; an unmapped address; a write to SWITCH; a read of LED/SEG; or MemRead=MemWrite=1.
REQ-027 On Addr_Err: no RAM or IO write, Read_Data=0, Stall=0, state stays IDLE.
REQ-028 When no access is requested: Read_Data=0, mem_we=0, Stall=0.
REQ-029 mem_we SHALL never be 1 outside IDLE.

Reset
REQ-030 While rst_n=0: state=IDLE, led_out=0, seg_out=0, synchronizer flops=0; Stall=0, mem_we=0, Addr_Err=0, Read_Data=0.
REQ-031 A reset asserted in RD_WAIT SHALL abort the load immediately; after release the block SHALL be in IDLE with Stall=0.

Verification
REQ-032 lw 0x0000_0010, RAM word 4 = 0x1234_5678 -> cycle 0 Stall=1, mem_addr=4; cycle 1 Stall=0, Read_Data=0x1234_5678; cycle 2 IDLE.
REQ-033 sw 0xDEAD_BEEF to 0x0000_0020 -> mem_we=1, mem_addr=8, Stall=0 for one cycle; a following lw of 0x20 returns 0xDEAD_BEEF.
REQ-034 Switch and LED access -> switch_in=0x00A5A5 visible after 2 synchronizer edges as Read_Data=0x0000_A5A5; sw 0x0012_3456 to 0xFFFF_FC60 -> led_out=0x123456 next edge.
REQ-035 lw 0x0000_0002, sw 0x1000_0000 and MemRead=MemWrite=1 -> Addr_Err=1 each cycle, mem_we=0, Read_Data=0, led_out unchanged.
REQ-036 rst_n pulsed low during RD_WAIT -> Stall=0 and state IDLE immediately; led_out=0; next lw completes normally in 2 cycles.
